// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared across the single-cycle MIPS core slice:
//   OPC_J / OPC_BEQ   primary opcodes of the control-flow instructions
//   NOP               instruction word handed to decode when nothing executes
//   ifu_state_e       fetch-unit run state (RUN, HALT)
//   RESET_PC_DEFAULT  PC loaded on reset
//   HALT_PC_DEFAULT   byte address of the last program instruction
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0]  OPC_J            = 6'h02;
    localparam logic [5:0]  OPC_BEQ          = 6'h04;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] HALT_PC_DEFAULT  = 32'h0000_0020;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch unit's control inputs, instruction-memory bus and debug
// outputs.
//   master : core/decode side - drives stall, branch/jump controls and imem_rd,
//            observes pc, instr, pc_plus4, halted, retired_cnt
//   slave  : the fetch unit itself
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 branch_taken;
    logic [15:0]          branch_imm;
    logic                 jump;
    logic [25:0]          jump_addr;
    logic [PC_WIDTH-1:0]  imem_rd;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  instr;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic                 halted;
    logic [CNT_WIDTH-1:0] retired_cnt;

    modport master (
        output stall, branch_taken, branch_imm, jump, jump_addr, imem_rd,
        input  pc, instr, pc_plus4, halted, retired_cnt
    );

    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_addr, imem_rd,
        output pc, instr, pc_plus4, halted, retired_cnt
    );
endinterface

// File: rtl/next_pc_logic.sv
// ---------------------------------------------------------------------------
// next_pc_logic
// Combinational next-PC selection for the fetch unit.
//   pc           in   current PC
//   branch_taken in   beq resolved taken
//   branch_imm   in   signed word offset of beq
//   jump         in   current instruction is j
//   jump_addr    in   26-bit j target field
//   pc_plus4     out  pc + 4 (modulo 2^PC_WIDTH)
//   next_pc      out  selected target; jump has priority over branch
// ---------------------------------------------------------------------------
module next_pc_logic #(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch_taken,
    input  logic [15:0]         branch_imm,
    input  logic                jump,
    input  logic [25:0]         jump_addr,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] next_pc
);
    logic [PC_WIDTH-1:0] branch_off;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;

    assign pc_plus4      = pc + PC_WIDTH'(4);
    // Word offset -> byte offset, sign-extended to the full PC width.
    assign branch_off    = {{(PC_WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    // j keeps the upper region bits of the sequential PC.
    assign jump_target   = {pc_plus4[PC_WIDTH-1:28], jump_addr, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Program counter owner for the single-cycle MIPS core. Drives the PC to
// instruction memory, forwards the fetched word to decode, advances the PC
// (sequential / beq / j), freezes on stall, halts for good once the HALT_PC
// instruction retires, and counts retired instructions for the debug display.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: stall, branch_taken, branch_imm, jump, jump_addr,
//          imem_rd in; pc, instr, pc_plus4, halted, retired_cnt out
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [PC_WIDTH-1:0] HALT_PC   = HALT_PC_DEFAULT,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_fetch_unit_if.slave  bus
);
    localparam logic [0:0] S_RUN  = ST_RUN;
    localparam logic [0:0] S_HALT = ST_HALT;

    logic [0:0]           state_reg, state_next;
    logic [PC_WIDTH-1:0]  pc_reg, pc_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic [PC_WIDTH-1:0]  target_pc;

    next_pc_logic #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
        .pc           (pc_reg),
        .branch_taken (bus.branch_taken),
        .branch_imm   (bus.branch_imm),
        .jump         (bus.jump),
        .jump_addr    (bus.jump_addr),
        .pc_plus4     (pc_plus4),
        .next_pc      (target_pc)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        if (state_reg == S_RUN && !bus.stall) begin
            // Every unstalled RUN edge retires one instruction; hold at all-ones.
            cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
            if (pc_reg == HALT_PC) begin
                // Final instruction retires here; the PC stays parked on it.
                state_next = S_HALT;
            end else begin
                pc_next = target_pc & ~PC_WIDTH'(3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RUN;
            pc_reg    <= RESET_PC;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.pc          = pc_reg;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr       = (state_reg == S_RUN) ? bus.imem_rd : NOP[PC_WIDTH-1:0];
    assign bus.halted      = (state_reg == S_HALT);
    assign bus.retired_cnt = cnt_reg;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    logic clk;
    logic rst_n;
    logic rst_sat_n;

    int checks;
    int failures;

    logic [31:0] rom [16];

    instruction_fetch_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) ifu_bus ();
    instruction_fetch_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(3))  sat_bus ();

    instruction_fetch_unit #(
        .PC_WIDTH (32), .RESET_PC (32'h0), .HALT_PC (32'h20), .CNT_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifu_bus)
    );

    // Narrow counter instance to reach saturation in a few cycles.
    instruction_fetch_unit #(
        .PC_WIDTH (32), .RESET_PC (32'h0), .HALT_PC (32'h20), .CNT_WIDTH (3)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_sat_n),
        .bus   (sat_bus)
    );

    assign ifu_bus.imem_rd = rom[ifu_bus.pc[5:2]];
    assign sat_bus.imem_rd = rom[sat_bus.pc[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        ifu_bus.stall        = 1'b0;
        ifu_bus.branch_taken = 1'b0;
        ifu_bus.branch_imm   = 16'h0;
        ifu_bus.jump         = 1'b0;
        ifu_bus.jump_addr    = 26'h0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // Factorial program image (word index = pc[5:2]).
        rom[0]  = 32'h2008_0005;  rom[1]  = 32'h2009_0001;
        rom[2]  = 32'h1100_0004;  rom[3]  = 32'h0128_0018;
        rom[4]  = 32'h0000_4812;  rom[5]  = 32'h2108_FFFF;
        rom[6]  = 32'h0800_0002;  rom[7]  = 32'hAC09_0000;
        rom[8]  = 32'h0800_0008;  rom[9]  = 32'h1111_1111;
        rom[10] = 32'h2222_2222;  rom[11] = 32'h3333_3333;
        rom[12] = 32'h4444_4444;  rom[13] = 32'h5555_5555;
        rom[14] = 32'h6666_6666;  rom[15] = 32'hDEAD_BEEF;

        rst_n     = 1'b0;
        rst_sat_n = 1'b0;
        clear_ctrl();
        sat_bus.stall        = 1'b0;
        sat_bus.branch_taken = 1'b0;
        sat_bus.branch_imm   = 16'h0;
        sat_bus.jump         = 1'b0;
        sat_bus.jump_addr    = 26'h0;

        repeat (2) step();
        check("reset_pc",     ifu_bus.pc,                  32'h0);
        check("reset_cnt",    32'(ifu_bus.retired_cnt),    32'h0);
        check("reset_halted", 32'(ifu_bus.halted),         32'h0);
        check("reset_instr",  ifu_bus.instr,               32'h2008_0005);
        check("reset_plus4",  ifu_bus.pc_plus4,            32'h4);
        rst_n = 1'b1;

        // Sequential fetch.
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_pc_%0d", i), ifu_bus.pc, 32'(4 * i));
        end
        check("seq_cnt", 32'(ifu_bus.retired_cnt), 32'd5);
        check("seq_instr", ifu_bus.instr, 32'h2108_FFFF);

        // Async reset mid-cycle at pc=0x14.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc",     ifu_bus.pc,               32'h0);
        check("async_cnt",    32'(ifu_bus.retired_cnt), 32'h0);
        check("async_halted", 32'(ifu_bus.halted),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forward branch from 0x10.
        repeat (4) step();
        check("pre_br_pc", ifu_bus.pc, 32'h10);
        ifu_bus.branch_taken = 1'b1;
        ifu_bus.branch_imm   = 16'h0003;
        step();
        check("br_fwd_pc", ifu_bus.pc, 32'h20);
        check("br_fwd_cnt", 32'(ifu_bus.retired_cnt), 32'd5);
        clear_ctrl();

        // Backward branch from 0x10.
        pulse_reset();
        repeat (4) step();
        ifu_bus.branch_taken = 1'b1;
        ifu_bus.branch_imm   = 16'hFFFD;
        step();
        check("br_back_pc", ifu_bus.pc, 32'h08);
        clear_ctrl();

        // Stall at 0x8 for 3 edges.
        ifu_bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), ifu_bus.pc, 32'h08);
            check($sformatf("stall_cnt_%0d", i), 32'(ifu_bus.retired_cnt), 32'd5);
        end
        check("stall_instr", ifu_bus.instr, 32'h1100_0004);
        ifu_bus.stall = 1'b0;
        step();
        check("unstall_pc", ifu_bus.pc, 32'h0C);
        check("unstall_cnt", 32'(ifu_bus.retired_cnt), 32'd6);

        // Jump beats branch at 0x1C.
        repeat (4) step();
        check("pre_j_pc", ifu_bus.pc, 32'h1C);
        ifu_bus.jump         = 1'b1;
        ifu_bus.jump_addr    = 26'h4;
        ifu_bus.branch_taken = 1'b1;
        ifu_bus.branch_imm   = 16'h0003;
        step();
        check("j_wins_pc", ifu_bus.pc, 32'h10);
        check("j_wins_cnt", 32'(ifu_bus.retired_cnt), 32'd11);
        clear_ctrl();

        // Branch to the top of the address space, then wrap through +4.
        ifu_bus.branch_taken = 1'b1;
        ifu_bus.branch_imm   = 16'hFFFA;
        step();
        check("br_top_pc", ifu_bus.pc, 32'hFFFF_FFFC);
        check("br_top_instr", ifu_bus.instr, 32'hDEAD_BEEF);
        check("top_plus4", ifu_bus.pc_plus4, 32'h0);
        clear_ctrl();
        step();
        check("wrap_pc", ifu_bus.pc, 32'h0);
        check("wrap_cnt", 32'(ifu_bus.retired_cnt), 32'd13);

        // Program run to HALT_PC.
        pulse_reset();
        repeat (8) step();
        check("pre_halt_pc", ifu_bus.pc, 32'h20);
        check("pre_halt_flag", 32'(ifu_bus.halted), 32'h0);
        check("pre_halt_instr", ifu_bus.instr, 32'h0800_0008);
        check("pre_halt_cnt", 32'(ifu_bus.retired_cnt), 32'd8);
        step();
        check("halt_flag", 32'(ifu_bus.halted), 32'h1);
        check("halt_pc", ifu_bus.pc, 32'h20);
        check("halt_instr", ifu_bus.instr, 32'h0);
        check("halt_cnt", 32'(ifu_bus.retired_cnt), 32'd9);
        ifu_bus.jump         = 1'b1;
        ifu_bus.jump_addr    = 26'h3FF_FFFF;
        ifu_bus.branch_taken = 1'b1;
        ifu_bus.branch_imm   = 16'h0001;
        step();
        check("halt_j_pc", ifu_bus.pc, 32'h20);
        check("halt_j_cnt", 32'(ifu_bus.retired_cnt), 32'd9);
        ifu_bus.jump  = 1'b0;
        ifu_bus.stall = 1'b1;
        step();
        check("halt_s_pc", ifu_bus.pc, 32'h20);
        check("halt_s_flag", 32'(ifu_bus.halted), 32'h1);
        check("halt_s_instr", ifu_bus.instr, 32'h0);
        clear_ctrl();

        // Counter saturation on the 3-bit instance.
        #2;
        rst_sat_n = 1'b1;
        repeat (7) step();
        check("sat_cnt_7", 32'(sat_bus.retired_cnt), 32'd7);
        check("sat_pc_7", sat_bus.pc, 32'h1C);
        step();
        check("sat_cnt_hold", 32'(sat_bus.retired_cnt), 32'd7);
        check("sat_pc_20", sat_bus.pc, 32'h20);
        step();
        check("sat_halted", 32'(sat_bus.halted), 32'h1);
        check("sat_cnt_halt", 32'(sat_bus.retired_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
